crack_sched: RTL and testbench
==============================

# crack_sched

Parametrised key-search scheduler for the ARC4 cracking datapath. It takes an inclusive key range and dispatches candidate keys in ascending order to `NUM_LANES` independent checker lanes. Each lane is a single-key decrypt-and-check engine with an en/rdy interface. The scheduler collects pass/fail results and reports the lowest matching key in the range, or no match. It generalises the single-engine 24-bit crack flow to any key width, any lane count, a programmable range, and abort.

## Interface
- `KEY_W`, 24, key width in bits
- `NUM_LANES`, 4, number of checker lanes (1..16)

- `clk`  in  1  clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  idle and able to accept `en`.
- `key_lo`  in  KEY_W  first key of the range; latched on accepted `en`.
- `key_hi`  in  KEY_W  last key of the range, inclusive; latched on accepted `en`.
- `abort`  in  1  stop dispatching and drain; ignored while `rdy`=1.
- `key`  out  KEY_W  lowest matching key; valid while `key_valid`=1.
- `key_valid`  out  1  the last search found a match.
- `keys_tried`  out  KEY_W+1  count of lane results collected in the current or last search.
- `lane_en`  out  NUM_LANES  one-cycle start pulse per lane.
- `lane_key`  out  NUM_LANES*KEY_W  candidate key for lane i, at bits [i*KEY_W +: KEY_W]; held stable while that lane is busy.
- `lane_rdy`  in  NUM_LANES  lane idle.
- `lane_done`  in  NUM_LANES  one-cycle completion pulse per lane.
- `lane_match`  in  NUM_LANES  pass result; qualified by `lane_done`.

## Operation
- **States:** IDLE, RUN, DRAIN, FIN.
- **IDLE:** `rdy`=1. On `en`, latch the range and clear `keys_tried`, `key_valid` and `key`.
  - If `key_lo`>`key_hi`, go to FIN.
  - Otherwise go to RUN with `next_key`=`key_lo`.
  - `next_key` is KEY_W+1 bits wide, so `key_hi`=all-ones terminates without wrap.
- **RUN, dispatch:** at most one dispatch per cycle. The target is the lowest-index lane with internal busy=0 and `lane_rdy`=1. That lane gets `lane_en` and `lane_key`=`next_key`, its busy bit is set, and `next_key` is incremented.
- **RUN, exit:** go to DRAIN on any of these:
  - `next_key`>`key_hi`;
  - any accepted `lane_match`;
  - `abort`.
- **Collection (RUN and DRAIN):** every `lane_done` clears that lane's busy bit and increments `keys_tried`.
  - A match with `lane_key` lower than the held best replaces `key` and sets `key_valid`.
  - For simultaneous matches, the lowest key wins.
- **Lowest-key guarantee:** keys are dispatched in ascending order and dispatch stops on the first match, so the minimum over drained results is the lowest match in the range.
- **DRAIN:** no dispatch. When all busy bits are 0, go to FIN.
- **FIN:** one cycle, then IDLE. `key`, `key_valid` and `keys_tried` hold until the next accepted `en`.
- **Abort:** no new dispatches; in-flight lanes are drained and their results still count. `key_valid` can therefore be 1 after an abort.
- **`lane_done` for a lane that is not busy:** ignored, and not counted.

## Timing
- **Reset values:** `rdy`=1, `key_valid`=0, `key`=0, `keys_tried`=0, `lane_en`=0, `lane_key`=0, state IDLE, busy bits 0. Reset mid-search abandons the search immediately. Lanes share `rst`.
- **Start:** `en` in cycle t → `rdy`=0 at t+1, first `lane_en` at t+1.
- **Dispatch rate:** one lane per cycle, so all idle lanes start within NUM_LANES cycles.
- **Lane reuse:** `lane_done` at cycle t frees that lane for redispatch at t+1.
- **Completion:** the last `lane_done` at t → FIN at t+1, `rdy`=1 at t+2.
- **Empty range:** `en` at t → `rdy`=1 at t+2, `key_valid`=0, `keys_tried`=0.
- **Lane contract:** `lane_rdy` drops the cycle after `lane_en`. The scheduler does not depend on it, because it uses its own busy bits.

## Structure
- **Package `crack_pkg`:** state enum `sched_state_t`; default `KEY_W`; the `lane_key` slice helper.
- **Sub-module `lane_pick`:** combinational lowest-index free-lane encoder. Outputs a grant one-hot and a found flag.
- **Compare:** the best-key update is a `lane_done`-masked minimum over lanes, written in the top.

## Test plan
- **Single key, match:** `NUM_LANES`=4, range 0x000010..0x000010, lane stub matches 0x10 after 5 cycles → `key`=0x000010, `key_valid`=1, `keys_tried`=1, `rdy` rises 2 cycles after `lane_done`.
- **Out-of-order match:** range 0..0xFF, stub matches 0x07 (latency 20) and 0x05 (latency 40) → `key`=0x000005, no dispatch beyond the first match cycle, all lanes drained.
- **No match:** range 0xFFFFF0..0xFFFFFF → `key_valid`=0, `keys_tried`=16, terminates with no wrap to 0.
- **Empty range:** `key_lo`=5, `key_hi`=4 → `rdy`=1 at t+2, no `lane_en`.
- **Abort:** abort after 6 dispatches, no matches → no further `lane_en`, `keys_tried`=6, `key_valid`=0.
- **Reset mid-RUN:** assert `rst` mid-RUN → all outputs at reset values that cycle; a new `en` afterwards searches normally.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared types and helpers for the ARC4 key-search scheduler.
package crack_pkg;

    // Default candidate key width in bits.
    localparam int KEY_W_DEFAULT = 24;

    // Scheduler control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } sched_state_t;

    // LSB position of lane `lane` inside the flattened lane_key bus.
    function automatic int lane_lsb(input int lane, input int key_w);
        return lane * key_w;
    endfunction

endpackage

// File: rtl/lane_pick.sv
// Lowest-index free-lane encoder: one-hot grant plus a found flag.
module lane_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] free_i,
    output logic [N-1:0] grant_o,
    output logic         found_o
);

    logic found;

    // Scan from lane 0 upward; the first free lane takes the grant.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (free_i[i] && !found) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/crack_sched.sv
// Key-search scheduler: dispatches keys key_lo..key_hi in ascending order to
// NUM_LANES checker lanes and reports the lowest matching key.
//
// Handshakes: a search starts when en_i=1 in a cycle where rdy_o=1 (en_i is
// ignored otherwise). A lane is started by a one-cycle lane_en_o pulse only
// when its internal busy bit is clear and lane_rdy_i=1; lane_key_o for that
// lane is stable from the pulse until its lane_done_i. A lane_done_i pulse is
// accepted only for a busy lane; lane_match_i is qualified by it.
module crack_sched
    import crack_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEFAULT,
    parameter int NUM_LANES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    output logic                       rdy_o,
    input  logic [KEY_W-1:0]           key_lo_i,
    input  logic [KEY_W-1:0]           key_hi_i,
    input  logic                       abort_i,
    output logic [KEY_W-1:0]           key_o,
    output logic                       key_valid_o,
    output logic [KEY_W:0]             keys_tried_o,
    output logic [NUM_LANES-1:0]       lane_en_o,
    output logic [NUM_LANES*KEY_W-1:0] lane_key_o,
    input  logic [NUM_LANES-1:0]       lane_rdy_i,
    input  logic [NUM_LANES-1:0]       lane_done_i,
    input  logic [NUM_LANES-1:0]       lane_match_i,
    output sched_state_t               state_o
);

    localparam logic [KEY_W:0] ONE = (KEY_W+1)'(1);

    sched_state_t         state_q, state_d;
    logic [KEY_W:0]       next_key_q, next_key_d;   // one extra bit so all-ones terminates
    logic [KEY_W:0]       key_hi_q, key_hi_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 key_valid_q, key_valid_d;
    logic [KEY_W:0]       tried_q, tried_d;
    logic [NUM_LANES-1:0] busy_q, busy_d;
    logic [KEY_W-1:0]     lane_key_q [NUM_LANES];
    logic [KEY_W-1:0]     lane_key_d [NUM_LANES];

    logic [NUM_LANES-1:0] free, grant, done_acc, dispatch_vec;
    logic                 found, dispatch, best_found;
    logic [KEY_W-1:0]     best_key;
    logic [KEY_W:0]       done_cnt;

    assign free = ~busy_q & lane_rdy_i;

    lane_pick #(.N(NUM_LANES)) u_lane_pick (
        .free_i  (free),
        .grant_o (grant),
        .found_o (found)
    );

    // Accepted completions: count them and take the lowest matching key among them.
    always_comb begin
        done_acc   = lane_done_i & busy_q;
        done_cnt   = '0;
        best_found = 1'b0;
        best_key   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (done_acc[i]) begin
                done_cnt = done_cnt + ONE;
                if (lane_match_i[i] && (!best_found || lane_key_q[i] < best_key)) begin
                    best_found = 1'b1;
                    best_key   = lane_key_q[i];
                end
            end
        end
    end

    // Dispatch stops as soon as the range is exhausted, a match lands, or abort is seen.
    always_comb begin
        dispatch     = (state_q == ST_RUN) && found && !abort_i && !best_found &&
                       (next_key_q <= key_hi_q);
        dispatch_vec = dispatch ? grant : '0;
    end

    // Next-state and datapath updates for the search FSM.
    always_comb begin
        state_d     = state_q;
        next_key_d  = next_key_q;
        key_hi_d    = key_hi_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        tried_d     = tried_q;
        busy_d      = busy_q;
        lane_key_d  = lane_key_q;

        if (state_q == ST_RUN || state_q == ST_DRAIN) begin
            busy_d  = (busy_q & ~done_acc) | dispatch_vec;
            tried_d = tried_q + done_cnt;
            if (best_found && (!key_valid_q || best_key < key_q)) begin
                key_d       = best_key;
                key_valid_d = 1'b1;
            end
            if (dispatch) begin
                next_key_d = next_key_q + ONE;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (dispatch_vec[i]) begin
                        lane_key_d[i] = next_key_q[KEY_W-1:0];
                    end
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    key_hi_d    = {1'b0, key_hi_i};
                    next_key_d  = {1'b0, key_lo_i};
                    tried_d     = '0;
                    key_valid_d = 1'b0;
                    key_d       = '0;
                    state_d     = (key_lo_i > key_hi_i) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (next_key_d > key_hi_q || best_found || abort_i) begin
                    state_d = (busy_d == '0) ? ST_FIN : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (busy_d == '0) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            next_key_q  <= '0;
            key_hi_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            tried_q     <= '0;
            busy_q      <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_key_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            next_key_q  <= next_key_d;
            key_hi_q    <= key_hi_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            tried_q     <= tried_d;
            busy_q      <= busy_d;
            lane_key_q  <= lane_key_d;
        end
    end

    // The dispatching lane sees next_key directly; busy lanes see their held key.
    always_comb begin
        lane_key_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_key_o[lane_lsb(i, KEY_W) +: KEY_W] =
                dispatch_vec[i] ? next_key_q[KEY_W-1:0] : lane_key_q[i];
        end
    end

    assign rdy_o        = (state_q == ST_IDLE);
    assign lane_en_o    = dispatch_vec;
    assign key_o        = key_q;
    assign key_valid_o  = key_valid_q;
    assign keys_tried_o = tried_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_crack_sched.sv
// Self-checking bench for crack_sched with behavioural checker-lane stubs.
module tb_crack_sched;
    import crack_pkg::*;

    localparam int KW = 24;
    localparam int NL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [KW-1:0]     key_lo_i = '0;
    logic [KW-1:0]     key_hi_i = '0;
    logic              rdy_o, key_valid_o;
    logic [KW-1:0]     key_o;
    logic [KW:0]       keys_tried_o;
    logic [NL-1:0]     lane_en_o;
    logic [NL-1:0]     lane_rdy_i, lane_done_i, lane_match_i;
    logic [NL*KW-1:0]  lane_key_o;
    sched_state_t      state_o;

    crack_sched #(.KEY_W(KW), .NUM_LANES(NL)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .rdy_o        (rdy_o),
        .key_lo_i     (key_lo_i),
        .key_hi_i     (key_hi_i),
        .abort_i      (abort_i),
        .key_o        (key_o),
        .key_valid_o  (key_valid_o),
        .keys_tried_o (keys_tried_o),
        .lane_en_o    (lane_en_o),
        .lane_key_o   (lane_key_o),
        .lane_rdy_i   (lane_rdy_i),
        .lane_done_i  (lane_done_i),
        .lane_match_i (lane_match_i),
        .state_o      (state_o)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Lane behaviour: which keys match, and per-key latency.
    bit  m_tab [int];
    int  lat_tab [int];
    int  def_lat = 3;
    bit  spur_en = 0;

    // Stub lane state.
    bit            s_busy [NL];
    int            s_cnt [NL];
    logic [KW-1:0] s_key [NL];
    bit            pend [NL];
    logic [KW-1:0] pend_key [NL];
    bit            real_done [NL];

    // Per-search observations.
    logic [KW-1:0] disp_q [$];
    int disp_cnt, done_cnt, proto_err;
    int first_disp_cyc, last_disp_cyc, last_done_cyc, first_match_cyc;
    int t_en, t_rdy;

    function automatic int lat_of(input logic [KW-1:0] k);
        return lat_tab.exists(int'(k)) ? lat_tab[int'(k)] : def_lat;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Lane stubs and monitor: observe at negedge, update lane outputs just after posedge.
    initial begin
        lane_rdy_i   = '1;
        lane_done_i  = '0;
        lane_match_i = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (real_done[i]) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (lane_match_i[i] && first_match_cyc < 0) first_match_cyc = cyc;
                end
                if (lane_en_o[i]) begin
                    if (s_busy[i] || real_done[i]) proto_err++;
                    pend[i]     = 1'b1;
                    pend_key[i] = lane_key_o[i*KW +: KW];
                    disp_q.push_back(lane_key_o[i*KW +: KW]);
                    if (disp_cnt == 0) first_disp_cyc = cyc;
                    disp_cnt++;
                    last_disp_cyc = cyc;
                end else if (s_busy[i] && lane_key_o[i*KW +: KW] !== s_key[i]) begin
                    proto_err++;
                end
            end
            @(posedge clk);
            #2;
            for (int i = 0; i < NL; i++) begin
                if (rst) begin
                    s_busy[i] = 1'b0; pend[i] = 1'b0; real_done[i] = 1'b0;
                    lane_done_i[i] = 1'b0; lane_match_i[i] = 1'b0;
                end else begin
                    real_done[i]    = 1'b0;
                    lane_done_i[i]  = 1'b0;
                    lane_match_i[i] = 1'b0;
                    if (s_busy[i]) begin
                        s_cnt[i]--;
                        if (s_cnt[i] == 0) begin
                            s_busy[i]       = 1'b0;
                            real_done[i]    = 1'b1;
                            lane_done_i[i]  = 1'b1;
                            lane_match_i[i] = m_tab.exists(int'(s_key[i]));
                        end
                    end else if (spur_en && !pend[i] && $urandom_range(0, 7) == 0) begin
                        lane_done_i[i]  = 1'b1;
                        lane_match_i[i] = 1'b1;
                    end
                    if (pend[i]) begin
                        pend[i]   = 1'b0;
                        s_busy[i] = 1'b1;
                        s_key[i]  = pend_key[i];
                        s_cnt[i]  = lat_of(pend_key[i]);
                    end
                end
                lane_rdy_i[i] = !s_busy[i];
            end
        end
    end

    // Start one search and wait (bounded) for rdy; optionally abort after N dispatches.
    task automatic run_search(input logic [KW-1:0] lo, input logic [KW-1:0] hi, input int abort_after);
        int n;
        bit ab_done;
        disp_q.delete();
        disp_cnt = 0; done_cnt = 0; proto_err = 0;
        first_disp_cyc = -1; last_disp_cyc = -1; last_done_cyc = -1; first_match_cyc = -1;
        ab_done = 0;
        @(posedge clk); #1;
        en_i = 1'b1; key_lo_i = lo; key_hi_i = hi; t_en = cyc;
        n = 0;
        do begin
            @(posedge clk); #1;
            en_i = 1'b0;
            abort_i = (abort_after >= 0) && !ab_done && (disp_cnt >= abort_after);
            if (abort_i) ab_done = 1;
            @(negedge clk);
            n++;
            if (n == 1) check("rdy_drop", rdy_o, 1'b0);
        end while (!rdy_o && n < 4000);
        abort_i = 1'b0;
        t_rdy = cyc;
        if (!rdy_o) begin
            check("timeout", rdy_o, 1'b1);
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input logic [KW-1:0] lo, input logic [KW-1:0] hi,
                                input logic ev, input logic [KW-1:0] ek, input int et, input bit timing);
        bit ok;
        check({tag, ".valid"}, key_valid_o, ev);
        check({tag, ".key"}, key_o, ek);
        check({tag, ".tried"}, keys_tried_o, (et >= 0) ? et : done_cnt);
        check({tag, ".drained"}, done_cnt, disp_cnt);
        ok = 1;
        foreach (disp_q[k]) begin
            if (int'(disp_q[k]) != int'(lo) + k || disp_q[k] > hi) ok = 0;
        end
        check({tag, ".order"}, ok, 1'b1);
        check({tag, ".proto"}, proto_err, 0);
        if (lo > hi) begin
            check({tag, ".empty_rdy"}, t_rdy, t_en + 2);
            check({tag, ".no_disp"}, disp_cnt, 0);
        end else begin
            check({tag, ".first_disp"}, first_disp_cyc, t_en + 1);
            if (timing) check({tag, ".fin"}, t_rdy, last_done_cyc + 2);
        end
        if (first_match_cyc >= 0) check({tag, ".stop"}, last_disp_cyc <= first_match_cyc, 1'b1);
    endtask

    typedef struct {
        logic [KW-1:0] lo, hi;
        int            nm;
        logic [KW-1:0] m0, m1;
        int            l0, l1, dlat;
        logic          ev;
        logic [KW-1:0] ek;
        int            et;
    } vec_t;

    vec_t vt [7];

    initial begin
        longint lo_l, hi_l;
        logic   ev;
        logic [KW-1:0] ek;

        vt[0] = '{24'h000010, 24'h000010, 1, 24'h10, 0, 5, 0, 3, 1'b1, 24'h10, 1};
        vt[1] = '{24'h000000, 24'h0000FF, 2, 24'h07, 24'h05, 20, 40, 4, 1'b1, 24'h05, -1};
        vt[2] = '{24'hFFFFF0, 24'hFFFFFF, 0, 0, 0, 0, 0, 2, 1'b0, 24'h0, 16};
        vt[3] = '{24'h000005, 24'h000004, 0, 0, 0, 0, 0, 2, 1'b0, 24'h0, 0};
        vt[4] = '{24'h000100, 24'h00010F, 1, 24'h10F, 0, 1, 0, 1, 1'b1, 24'h10F, 16};
        vt[5] = '{24'h000020, 24'h00003F, 2, 24'h30, 24'h21, 1, 9, 2, 1'b1, 24'h21, -1};
        vt[6] = '{24'h000000, 24'h000003, 2, 24'h00, 24'h02, 3, 1, 2, 1'b1, 24'h00, -1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.rdy", rdy_o, 1'b1);
        check("rst.valid", key_valid_o, 1'b0);
        check("rst.key", key_o, '0);
        check("rst.tried", keys_tried_o, '0);
        check("rst.lane_en", lane_en_o, '0);
        check("rst.lane_key", lane_key_o, '0);
        @(posedge clk); #1; rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            m_tab.delete(); lat_tab.delete();
            spur_en = 0;
            def_lat = vt[i].dlat;
            if (vt[i].nm >= 1) begin m_tab[int'(vt[i].m0)] = 1; lat_tab[int'(vt[i].m0)] = vt[i].l0; end
            if (vt[i].nm >= 2) begin m_tab[int'(vt[i].m1)] = 1; lat_tab[int'(vt[i].m1)] = vt[i].l1; end
            run_search(vt[i].lo, vt[i].hi, -1);
            check_result($sformatf("vec%0d", i), vt[i].lo, vt[i].hi, vt[i].ev, vt[i].ek, vt[i].et, 1);
        end

        // Abort after six dispatches with no matches.
        m_tab.delete(); lat_tab.delete(); def_lat = 3;
        run_search(24'h0, 24'hFF, 6);
        check_result("abort", 24'h0, 24'hFF, 1'b0, 24'h0, 6, 0);

        // Reset in the middle of a search, then a normal search.
        m_tab.delete(); def_lat = 4;
        @(posedge clk); #1;
        en_i = 1'b1; key_lo_i = 24'h0; key_hi_i = 24'hFFFF;
        @(posedge clk); #1; en_i = 1'b0;
        repeat (12) @(posedge clk);
        #1; rst = 1'b1;
        @(negedge clk);
        check("midrst.rdy", rdy_o, 1'b1);
        check("midrst.valid", key_valid_o, 1'b0);
        check("midrst.key", key_o, '0);
        check("midrst.tried", keys_tried_o, '0);
        check("midrst.lane_en", lane_en_o, '0);
        check("midrst.lane_key", lane_key_o, '0);
        @(posedge clk); #1; rst = 1'b0;
        m_tab[int'(24'h43)] = 1;
        run_search(24'h40, 24'h4F, -1);
        check_result("after_rst", 24'h40, 24'h4F, 1'b1, 24'h43, -1, 1);

        // Randomized searches against a range-level reference model.
        for (int r = 0; r < 12; r++) begin
            m_tab.delete(); lat_tab.delete();
            spur_en = 1;
            def_lat = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) lo_l = 64'hFFFFFF - longint'($urandom_range(0, 30));
            else lo_l = longint'($urandom_range(0, 24'hFFFFFF));
            hi_l = lo_l + longint'($urandom_range(0, 40));
            if (hi_l > 64'hFFFFFF) hi_l = 64'hFFFFFF;
            for (longint k = lo_l; k <= hi_l; k++) begin
                if ($urandom_range(0, 9) == 0) m_tab[int'(k)] = 1;
                lat_tab[int'(k)] = $urandom_range(1, 12);
            end
            ev = 1'b0; ek = '0;
            for (longint k = lo_l; k <= hi_l; k++) begin
                if (!ev && m_tab.exists(int'(k))) begin ev = 1'b1; ek = KW'(k); end
            end
            run_search(KW'(lo_l), KW'(hi_l), -1);
            check_result($sformatf("rand%0d", r), KW'(lo_l), KW'(hi_l), ev, ek,
                         ev ? -1 : int'(hi_l - lo_l + 1), 1);
        end
        spur_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
